// File: rtl/card_dealer.sv
// card_dealer: random card source for the Blackjack game FSM.
// Deals one not-yet-dealt card of a 52-card deck per deal request.
//
// Ports:
//   clk          system clock (50 MHz)
//   reset_n      asynchronous active-low reset
//   deal_req     one-cycle pulse: deal one card
//   shuffle_req  one-cycle pulse: return all cards to the deck
//   card_valid   one-cycle pulse: card_* carry a newly dealt card
//   card_rank    1..13 (A, 2..10, J, Q, K), held until next deal
//   card_suit    0..3, held until next deal
//   card_value   Blackjack value (A=1, face cards=10), held
//   cards_left   undealt cards, 0..52
//   deck_empty   high when cards_left == 0
//   busy         high while searching for or emitting a card
module card_dealer #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          DECK_SIZE = 52
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       deal_req,
    input  logic       shuffle_req,
    output logic       card_valid,
    output logic [3:0] card_rank,
    output logic [1:0] card_suit,
    output logic [4:0] card_value,
    output logic [5:0] cards_left,
    output logic       deck_empty,
    output logic       busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SEARCH = 2'd1;
    localparam logic [1:0] EMIT   = 2'd2;

    localparam logic [5:0] FULL = 6'(DECK_SIZE);
    localparam logic [5:0] LAST = 6'(DECK_SIZE - 1);

    logic [1:0]  state;
    logic [15:0] lfsr;
    logic [15:0] lfsr_next;
    logic [51:0] used;
    logic [5:0]  probe;
    logic [5:0]  probe_next;
    logic [5:0]  cand;
    logic        probe_used;

    logic [1:0]  emit_suit;
    logic [5:0]  emit_off;
    logic [3:0]  emit_rank;
    logic [4:0]  emit_value;

    // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
    always_comb begin
        lfsr_next = {1'b0, lfsr[15:1]};
        if (lfsr[0]) begin
            lfsr_next = lfsr_next ^ 16'hB400;
        end
    end

    // Fold 52..63 back onto 40..51 so every draw is a legal index.
    always_comb begin
        cand = lfsr[5:0];
        if (lfsr[5:0] >= FULL) begin
            cand = lfsr[5:0] - 6'd12;
        end
    end

    assign probe_used = used[probe];

    // Linear probing with wrap; cards_left > 0 guarantees a hit.
    always_comb begin
        probe_next = probe + 6'd1;
        if (probe == LAST) begin
            probe_next = 6'd0;
        end
    end

    // probe / 13 and probe % 13 without a divider.
    always_comb begin
        emit_suit = 2'd0;
        emit_off  = probe;
        if (probe >= 6'd39) begin
            emit_suit = 2'd3;
            emit_off  = probe - 6'd39;
        end else if (probe >= 6'd26) begin
            emit_suit = 2'd2;
            emit_off  = probe - 6'd26;
        end else if (probe >= 6'd13) begin
            emit_suit = 2'd1;
            emit_off  = probe - 6'd13;
        end
    end

    always_comb begin
        emit_rank  = emit_off[3:0] + 4'd1;
        emit_value = {1'b0, emit_rank};
        if (emit_rank > 4'd10) begin
            emit_value = 5'd10;
        end
    end

    // The LFSR never stalls, so request timing seeds each draw.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= lfsr_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            used       <= '0;
            probe      <= '0;
            cards_left <= FULL;
            deck_empty <= 1'b0;
            busy       <= 1'b0;
            card_valid <= 1'b0;
            card_rank  <= '0;
            card_suit  <= '0;
            card_value <= '0;
        end else begin
            card_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    // Shuffle wins; a coincident deal is dropped.
                    if (shuffle_req) begin
                        used       <= '0;
                        cards_left <= FULL;
                        deck_empty <= 1'b0;
                    end else if (deal_req && cards_left != 6'd0) begin
                        probe <= cand;
                        state <= SEARCH;
                        busy  <= 1'b1;
                    end
                end
                SEARCH: begin
                    if (!probe_used) begin
                        state <= EMIT;
                    end else begin
                        probe <= probe_next;
                    end
                end
                EMIT: begin
                    used[probe] <= 1'b1;
                    cards_left  <= cards_left - 6'd1;
                    deck_empty  <= (cards_left == 6'd1);
                    card_suit   <= emit_suit;
                    card_rank   <= emit_rank;
                    card_value  <= emit_value;
                    card_valid  <= 1'b1;
                    state       <= IDLE;
                    busy        <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/card_dealer.md
Name: card_dealer

Overview:
- Random card source for the Blackjack game FSM; sits directly upstream of the game logic driven by the hit key.
- On a one-cycle deal request it returns one card not yet dealt from a 52-card deck.
- Tracks used cards and reshuffles on request.
- Uses a free-running LFSR, so key-press timing seeds the draw.

Parameters:
- LFSR_SEED, 16'hACE1, LFSR value loaded at reset; must be nonzero.
- DECK_SIZE, 52, cards per deck. Fixed at 52; the index mapping below depends on it.

Ports:
- clk  input  1  system clock, 50 MHz.
- reset_n  input  1  asynchronous, active-low reset.
- deal_req  input  1  one-cycle pulse from the game FSM requesting one card.
- shuffle_req  input  1  one-cycle pulse that returns all cards to the deck.
- card_valid  output  1  one-cycle pulse: card_* outputs carry a newly dealt card.
- card_rank  output  4  1..13 (A, 2..10, J, Q, K).
- card_suit  output  2  0..3.
- card_value  output  5  Blackjack value: A=1, 2..10=rank, J/Q/K=10. The game FSM handles soft aces.
- cards_left  output  6  undealt cards, 0..52.
- deck_empty  output  1  high when cards_left==0.
- busy  output  1  high while in SEARCH or EMIT.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, used mask = 52'b0, cards_left=52, lfsr=LFSR_SEED.
  - card_valid=0, card_rank=0, card_suit=0, card_value=0, deck_empty=0, busy=0.
  - Reset asserted mid-SEARCH or mid-EMIT aborts the deal: no card_valid, no card marked used.
- LFSR:
  - 16-bit Galois LFSR, taps x^16+x^14+x^13+x^11+1.
  - Advances every clock in every state, never stalls.
- Candidate index: cand = lfsr[5:0]; if cand>=52 then cand = cand-12, giving a range of 0..51.
- State IDLE:
  - If shuffle_req: clear used mask, cards_left=52, stay IDLE. shuffle_req wins over a simultaneous deal_req; that deal_req is dropped.
  - Else if deal_req and cards_left>0: latch cand into a probe register, go to SEARCH.
  - Else if deal_req and cards_left==0: ignored. No card_valid; stay IDLE.
- State SEARCH, one probe per cycle:
  - If used[probe]==0: go to EMIT.
  - Else probe = (probe==51) ? 0 : probe+1 and stay. Wrap-around 51->0 is required.
  - Termination is guaranteed because cards_left>0; at most 52 SEARCH cycles.
- State EMIT, one cycle:
  - Set used[probe]=1, cards_left decrements by 1.
  - Register card_suit = probe/13 and card_rank = probe%13 + 1; card_value mapped from rank.
  - card_valid=1 for exactly this one cycle. Return to IDLE.
- Latency: deal_req sampled at edge N; first probe evaluated in the cycle after N.
  - First probe free: card_valid is high in the cycle following edge N+2.
  - Each occupied probe adds exactly 1 cycle.
- card_rank, card_suit and card_value hold their last dealt values until the next EMIT or reset. shuffle_req does not clear them.
- deal_req or shuffle_req while busy=1 is ignored, not queued.
- deck_empty and cards_left update on the same edge as the EMIT or shuffle that changes them.
- All outputs are registered.

Test Plan:
- Reset, then hold reset_n=0 for 5 cycles:
  - During reset: cards_left=52, deck_empty=0, card_valid=0, busy=0, card_rank=0.
  - After release: outputs stay at those values until the first request.
- Single deal_req pulse:
  - Exactly one card_valid pulse, at least 3 cycles after the request edge.
  - card_rank in 1..13; card_value matches rank (J/Q/K=10, A=1).
  - cards_left=51.
- 52 deal_req pulses, each after the previous card_valid:
  - All 52 {suit,rank} pairs are distinct; each deal waits at most 54 cycles.
  - Final state: cards_left=0, deck_empty=1.
  - A 53rd deal_req gives no card_valid within 60 cycles and cards_left stays 0.
- From the empty deck, pulse shuffle_req:
  - Next cycle: cards_left=52, deck_empty=0.
  - A subsequent deal_req returns a valid card and cards_left=51.
- deal_req and shuffle_req in the same IDLE cycle, after 10 dealt cards:
  - cards_left=52 and no card_valid.
  - A second deal_req pulsed while busy=1 produces only one card_valid.
- Assert reset_n=0 while busy=1 in SEARCH:
  - busy drops asynchronously and card_valid never pulses.
  - cards_left=52 after release.
